// File: rtl/mux_wrr_scheduler_pkg.sv
// Shared types for the packet-level WRR scheduler.
// FSM encoding, IDLE-cycle action flags, width helpers.
package mux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int WEIGHT_W = 4;
  localparam int CREDIT_W = WEIGHT_W;

  // What an IDLE cycle does: issue a grant or reload credits
  typedef struct packed {
    logic grant;
    logic refill;
  } idle_act_t;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_wrr_scheduler_if.sv
// Scheduler <-> mux bundle: queue flags, output handshake, grant.
// master = scheduler side, slave = mux side.
interface mux_wrr_scheduler_if #(
  parameter int NUM_QUEUES = 3
) ();
  import mux_sched_pkg::*;

  localparam int IDX_W = clog2(NUM_QUEUES);

  logic [NUM_QUEUES-1:0] q_nonempty;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;
  logic                  grant_valid;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_QUEUES-1:0] grant_onehot;

  modport master (
    input  q_nonempty,
    input  m_axis_tvalid,
    input  m_axis_tready,
    input  m_axis_tlast,
    output grant_valid,
    output grant_idx,
    output grant_onehot
  );

  modport slave (
    output q_nonempty,
    output m_axis_tvalid,
    output m_axis_tready,
    output m_axis_tlast,
    input  grant_valid,
    input  grant_idx,
    input  grant_onehot
  );

endinterface

// File: rtl/mux_wrr_scheduler_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr.
// Search wraps from N-1 back to 0.
module rr_pick
  import mux_sched_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  found,
  output logic [clog2(N)-1:0]   idx
);

  localparam int IW = clog2(N);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_wrr_scheduler.sv
// Packet-level weighted round-robin grant for the 3-input AXI-S mux.
// Optional per-queue packet counters: define MUX_SCHED_STATS_EN.
module mux_wrr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int NUM_QUEUES     = 3,
  parameter int WEIGHT_WIDTH   = WEIGHT_W,
  parameter int DEFAULT_WEIGHT = 1,
  parameter int STAT_WIDTH     = 32
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  mux_wrr_scheduler_if.master              sif,
  input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] cfg_weight,
  input  logic                             cfg_load,
  output logic [NUM_QUEUES*STAT_WIDTH-1:0] stat_pkt_cnt,
  input  logic                             stat_clr
);

  localparam int IW = clog2(NUM_QUEUES);
  localparam logic [WEIGHT_WIDTH-1:0] DEF_W =
    WEIGHT_WIDTH'(DEFAULT_WEIGHT);
  localparam logic [IW-1:0] LAST_Q = IW'(NUM_QUEUES - 1);

  logic [WEIGHT_WIDTH-1:0] wgt_q [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] shd_q [NUM_QUEUES];
  logic [WEIGHT_WIDTH-1:0] crd_q [NUM_QUEUES];

  state_t                state_q, state_d;
  idle_act_t             act;
  logic                  do_eop;
  logic [IW-1:0]         ptr_q, gidx_q, g_nxt;
  logic                  gval_q;
  logic [NUM_QUEUES-1:0] goh_q;
  logic [NUM_QUEUES-1:0] eligible, wnz;
  logic                  pick_ok, need_refill, eop;
  logic [IW-1:0]         pick_idx;

  always_comb begin
    for (int i = 0; i < NUM_QUEUES; i++) begin
      eligible[i] = sif.q_nonempty[i] & (crd_q[i] != '0);
      wnz[i]      = (wgt_q[i] != '0);
    end
  end

  assign need_refill = |(sif.q_nonempty & wnz);
  assign eop = sif.m_axis_tvalid & sif.m_axis_tready
             & sif.m_axis_tlast;
  assign g_nxt = (gidx_q == LAST_Q) ? '0 : gidx_q + 1'b1;

  rr_pick #(.N(NUM_QUEUES)) u_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .found (pick_ok),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    act     = '0;
    do_eop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          pick_ok: begin
            act.grant = 1'b1;
            state_d   = BUSY;
          end
          (!pick_ok && need_refill): act.refill = 1'b1;
          default: ;
        endcase
      end
      BUSY: begin
        if (eop) begin
          do_eop  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gval_q  <= 1'b0;
      goh_q   <= '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        wgt_q[i] <= DEF_W;
        shd_q[i] <= DEF_W;
        crd_q[i] <= DEF_W;
      end
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        for (int i = 0; i < NUM_QUEUES; i++)
          shd_q[i] <= cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
      // Old shadow is applied here even if cfg_load fires now
      if (act.refill) begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
          wgt_q[i] <= shd_q[i];
          crd_q[i] <= shd_q[i];
        end
      end
      if (act.grant) begin
        gval_q <= 1'b1;
        gidx_q <= pick_idx;
        goh_q  <= NUM_QUEUES'(1) << pick_idx;
      end
      if (do_eop) begin
        gval_q <= 1'b0;
        goh_q  <= '0;
        if (crd_q[gidx_q] != '0)
          crd_q[gidx_q] <= crd_q[gidx_q] - 1'b1;
        ptr_q <= (crd_q[gidx_q] <= 1) ? g_nxt : gidx_q;
      end
    end
  end

  assign sif.grant_valid  = gval_q;
  assign sif.grant_idx    = gidx_q;
  assign sif.grant_onehot = goh_q;

`ifdef MUX_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_QUEUES];

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      for (int i = 0; i < NUM_QUEUES; i++)
        stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_QUEUES; i++)
        stat_q[i] <= '0;
    end else if (do_eop && stat_q[gidx_q] != '1) begin
      stat_q[gidx_q] <= stat_q[gidx_q] + 1'b1;
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int i = 0; i < NUM_QUEUES; i++)
      stat_pkt_cnt[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_pkt_cnt    = '0;
`endif

endmodule

// File: tb/tb_mux_wrr_scheduler.sv
// Scoreboard bench for mux_wrr_scheduler: expected grant order
// and EOP-to-grant gaps are queued per scenario.
module tb_mux_wrr_scheduler;
  import mux_sched_pkg::*;

  localparam int NQ = 3;
  localparam int WW = 4;
  localparam int SW = 32;

  logic             axis_aclk = 1'b0;
  logic             axis_resetn = 1'b0;
  logic [NQ*WW-1:0] cfg_weight = '0;
  logic             cfg_load = 1'b0;
  logic             stat_clr = 1'b0;
  logic [NQ*SW-1:0] stat_pkt_cnt;

  mux_wrr_scheduler_if #(.NUM_QUEUES(NQ)) sif ();

  mux_wrr_scheduler #(
    .NUM_QUEUES     (NQ),
    .WEIGHT_WIDTH   (WW),
    .DEFAULT_WEIGHT (1),
    .STAT_WIDTH     (SW)
  ) dut (
    .axis_aclk    (axis_aclk),
    .axis_resetn  (axis_resetn),
    .sif          (sif),
    .cfg_weight   (cfg_weight),
    .cfg_load     (cfg_load),
    .stat_pkt_cnt (stat_pkt_cnt),
    .stat_clr     (stat_clr)
  );

  always #5 axis_aclk = ~axis_aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int gap_q[$];

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic do_reset();
    axis_resetn       = 1'b0;
    sif.q_nonempty    = '0;
    sif.m_axis_tvalid = 1'b0;
    sif.m_axis_tready = 1'b1;
    sif.m_axis_tlast  = 1'b0;
    cfg_load          = 1'b0;
    stat_clr          = 1'b0;
    exp_q.delete();
    gap_q.delete();
    tick();
    tick();
    axis_resetn = 1'b1;
  endtask

  task automatic load_cfg(input logic [NQ*WW-1:0] w);
    cfg_weight = w;
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  // gap: 1 = regrant one cycle after drop, 2 = refill first, 0 = no check
  task automatic expect_grant(input int idx, input int gap);
    exp_q.push_back(idx);
    gap_q.push_back(gap);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sif.grant_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: grant_valid=%b required 1",
               sif.grant_valid);
    end
  endtask

  task automatic send_pkt(input int len);
    for (int b = 0; b < len; b++) begin
      sif.m_axis_tvalid = 1'b1;
      sif.m_axis_tlast  = (b == len - 1);
      tick();
    end
    sif.m_axis_tvalid = 1'b0;
    sif.m_axis_tlast  = 1'b0;
  endtask

  task automatic run_queue(input int len);
    int e, gap;
    bit ok;
    logic [NQ-1:0] eoh;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      gap = gap_q.pop_front();
      eoh = NQ'(1) << e;
      wait_grant(ok);
      if (!ok) begin
        exp_q.delete();
        gap_q.delete();
        return;
      end
      n_checks++;
      if (sif.grant_idx !== 2'(e)) begin
        n_fail++;
        $display("FAIL grant_idx: got %0d required %0d",
                 sif.grant_idx, e);
      end
      n_checks++;
      if (sif.grant_onehot !== eoh) begin
        n_fail++;
        $display("FAIL grant_onehot: got %b required %b",
                 sif.grant_onehot, eoh);
      end
      send_pkt(len);
      n_checks++;
      if (sif.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL eop_drop: grant_valid=%b required 0",
                 sif.grant_valid);
      end
      if (gap == 2) begin
        tick();
        n_checks++;
        if (sif.grant_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL refill_gap: grant_valid=%b required 0",
                   sif.grant_valid);
        end
      end
      if (gap >= 1) begin
        tick();
        n_checks++;
        if (sif.grant_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL regrant: grant_valid=%b required 1",
                   sif.grant_valid);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    axis_resetn = 1'b0;
    #1;
    n_checks++;
    if (sif.grant_valid !== 1'b0 || sif.grant_idx !== 2'd0 ||
        sif.grant_onehot !== 3'b000 || stat_pkt_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b idx=%0d oh=%b stat=%h required 0",
               sif.grant_valid, sif.grant_idx, sif.grant_onehot,
               stat_pkt_cnt);
    end
    tick();
    axis_resetn = 1'b1;
    tick();
    tick();
    n_checks++;
    if (sif.grant_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_empty: grant_valid=%b required 0",
               sif.grant_valid);
    end
  endtask

  task automatic test_equal_weights();
    do_reset();
    sif.q_nonempty = 3'b111;
    tick();
    n_checks++;
    if (sif.grant_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant_latency: grant_valid=%b required 1",
               sif.grant_valid);
    end
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 2);
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 0);
    run_queue(1);
  endtask

  task automatic test_weights_312();
    do_reset();
    load_cfg({4'd2, 4'd1, 4'd3});
    sif.q_nonempty = 3'b111;
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 2);
    for (int r = 0; r < 2; r++) begin
      expect_grant(0, 1);
      expect_grant(0, 1);
      expect_grant(0, 1);
      expect_grant(1, 1);
      expect_grant(2, 1);
      expect_grant(2, (r == 0) ? 2 : 0);
    end
    run_queue(1);
  endtask

  task automatic test_single_queue();
    do_reset();
    sif.q_nonempty = 3'b010;
    expect_grant(1, 2);
    expect_grant(1, 2);
    expect_grant(1, 0);
    run_queue(1);
  endtask

  task automatic test_cfg_mid_round();
    do_reset();
    sif.q_nonempty = 3'b111;
    expect_grant(0, 1);
    run_queue(2);
    load_cfg({4'd0, 4'd2, 4'd0});
    expect_grant(1, 1);
    expect_grant(2, 2);
    expect_grant(1, 1);
    expect_grant(1, 2);
    expect_grant(1, 1);
    expect_grant(1, 0);
    run_queue(2);
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    do_reset();
    load_cfg({4'd3, 4'd3, 4'd3});
    sif.q_nonempty = 3'b111;
    wait_grant(ok);
    sif.m_axis_tvalid = 1'b1;
    sif.m_axis_tlast  = 1'b0;
    tick();
    tick();
    sif.m_axis_tvalid = 1'b0;
    tick();
    n_checks++;
    if (sif.grant_valid !== 1'b1 || sif.grant_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_no_tlast: v=%b idx=%0d required 1/0",
               sif.grant_valid, sif.grant_idx);
    end
    axis_resetn = 1'b0;
    #1;
    n_checks++;
    if (sif.grant_valid !== 1'b0 || sif.grant_onehot !== 3'b000) begin
      n_fail++;
      $display("FAIL async_abort: v=%b oh=%b required 0/000",
               sif.grant_valid, sif.grant_onehot);
    end
    tick();
    axis_resetn = 1'b1;
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 2);
    expect_grant(0, 1);
    expect_grant(1, 0);
    run_queue(1);
  endtask

  task automatic test_all_zero();
    do_reset();
    load_cfg('0);
    sif.q_nonempty = 3'b111;
    expect_grant(0, 1);
    expect_grant(1, 1);
    expect_grant(2, 0);
    run_queue(1);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (sif.grant_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_weight_idle: cycle %0d grant_valid=%b required 0",
                 i, sif.grant_valid);
      end
    end
  endtask

  task automatic test_stats();
    bit ok;
    do_reset();
    sif.q_nonempty = 3'b100;
    for (int i = 0; i < 5; i++)
      expect_grant(2, 2);
    run_queue(1);
`ifdef MUX_SCHED_STATS_EN
    n_checks++;
    if (stat_pkt_cnt !== {32'd5, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL stat_count: got %h required cnt2=5 others 0",
               stat_pkt_cnt);
    end
    wait_grant(ok);
    stat_clr          = 1'b1;
    sif.m_axis_tvalid = 1'b1;
    sif.m_axis_tlast  = 1'b1;
    tick();
    stat_clr          = 1'b0;
    sif.m_axis_tvalid = 1'b0;
    sif.m_axis_tlast  = 1'b0;
    n_checks++;
    if (stat_pkt_cnt[2*SW +: SW] !== 32'd0) begin
      n_fail++;
      $display("FAIL stat_clr_wins: got %0d required 0",
               stat_pkt_cnt[2*SW +: SW]);
    end
    expect_grant(2, 0);
    run_queue(1);
    n_checks++;
    if (stat_pkt_cnt[2*SW +: SW] !== 32'd1) begin
      n_fail++;
      $display("FAIL stat_after_clr: got %0d required 1",
               stat_pkt_cnt[2*SW +: SW]);
    end
`else
    wait_grant(ok);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_checks++;
    if (stat_pkt_cnt !== '0) begin
      n_fail++;
      $display("FAIL stat_disabled: got %h required 0", stat_pkt_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_equal_weights();
    test_weights_312();
    test_single_queue();
    test_cfg_mid_round();
    test_reset_mid_packet();
    test_all_zero();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
